// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer
//   Turns one register command (write one byte, or read N bytes) into the
//   byte-level handshake stream expected by the I2C interface model.
//   Write: {DEV,0}, REG, WDATA.  Read: {DEV,0}, REG, {DEV,1}, then LEN
//   receive bytes.
//
// Optional build macro: I2C_SEQ_WDOG_EN
//   Defined   -> per-wait-state watchdog of WDOG_CYC cycles; on expiry the
//                command aborts with DONE and ERR_TIMEOUT pulsed together.
//   Undefined -> no watchdog counter, ERR_TIMEOUT tied low, waits unbounded.
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   CMD_VALID/READY     command handshake (READY high only while idle)
//   CMD_RNW             1 = read, 0 = write
//   CMD_DEV_ADDR        7-bit device address
//   CMD_REG_ADDR        register address
//   CMD_WDATA           write data byte
//   CMD_LEN             read byte count (0 = address phase only)
//   RD_DATA/RD_VALID    captured read byte, one-cycle valid pulse
//   DONE                one-cycle pulse at command end (normal or abort)
//   BUSY                command in progress
//   ERR_TIMEOUT         one-cycle pulse with DONE on watchdog abort
//   TX_DATA/TX_WE       byte and write strobe to model DIN/WE_IN
//   TX_RDY              model RDY_IN
//   RX_DATA/RX_WE_N     model DOUT and its active-low write strobe
//   RX_REQ              model RDY_OUT (request next receive byte)
module i2c_cmd_sequencer #(
  parameter int LEN_W    = 4,
  parameter int WDOG_CYC = 4096,
  parameter int WDOG_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_RNW,
  input  logic [6:0]       CMD_DEV_ADDR,
  input  logic [7:0]       CMD_REG_ADDR,
  input  logic [7:0]       CMD_WDATA,
  input  logic [LEN_W-1:0] CMD_LEN,
  output logic [7:0]       RD_DATA,
  output logic             RD_VALID,
  output logic             DONE,
  output logic             BUSY,
  output logic             ERR_TIMEOUT,
  output logic [7:0]       TX_DATA,
  output logic             TX_WE,
  input  logic             TX_RDY,
  input  logic [7:0]       RX_DATA,
  input  logic             RX_WE_N,
  output logic             RX_REQ
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_LOAD       = 4'd1;
  localparam logic [3:0] S_SEND       = 4'd2;
  localparam logic [3:0] S_WAIT_HI    = 4'd3;
  localparam logic [3:0] S_WAIT_LO    = 4'd4;
  localparam logic [3:0] S_NEXT       = 4'd5;
  localparam logic [3:0] S_RD_REQ     = 4'd6;
  localparam logic [3:0] S_RD_WAIT_HI = 4'd7;
  localparam logic [3:0] S_FINISH     = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             rnw_q, rnw_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       reg_q, reg_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wdog_hit;
  logic             tmo_set;

  // Byte idx of the transmit phase; the third byte differs between read
  // (repeated-start address with R/W=1) and write (data byte).
  function automatic logic [7:0] byte_sel(input logic [1:0] idx,
                                          input logic       rnw,
                                          input logic [6:0] dev,
                                          input logic [7:0] reg_a,
                                          input logic [7:0] wd);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {dev, 1'b0};
      2'd1:    b = reg_a;
      default: b = rnw ? {dev, 1'b1} : wd;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    rnw_d      = rnw_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    tx_data_d  = tx_data_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    tmo_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          rnw_d   = CMD_RNW;
          dev_d   = CMD_DEV_ADDR;
          reg_d   = CMD_REG_ADDR;
          wdata_d = CMD_WDATA;
          rem_d   = CMD_LEN;
          idx_d   = 2'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_data_d = byte_sel(idx_q, rnw_q, dev_q, reg_q, wdata_q);
        state_d   = S_SEND;
      end
      S_SEND: state_d = S_WAIT_HI;
      S_WAIT_HI: begin
        if (TX_RDY) begin
          state_d = S_WAIT_LO;
        end else if (wdog_hit) begin
          state_d = S_FINISH;
          tmo_set = 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!TX_RDY) begin
          state_d = S_NEXT;
        end else if (wdog_hit) begin
          state_d = S_FINISH;
          tmo_set = 1'b1;
        end
      end
      S_NEXT: begin
        if (idx_q != 2'd2) begin
          idx_d   = idx_q + 2'd1;
          state_d = S_LOAD;
        end else if (rnw_q && (rem_q != '0)) begin
          state_d = S_RD_REQ;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_RD_REQ: begin
        if (!RX_WE_N) begin
          rd_data_d  = RX_DATA;
          rd_valid_d = 1'b1;
          state_d    = S_RD_WAIT_HI;
        end else if (wdog_hit) begin
          state_d = S_FINISH;
          tmo_set = 1'b1;
        end
      end
      S_RD_WAIT_HI: begin
        if (RX_WE_N) begin
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? S_FINISH : S_RD_REQ;
        end else if (wdog_hit) begin
          state_d = S_FINISH;
          tmo_set = 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      rem_q      <= '0;
      rnw_q      <= 1'b0;
      dev_q      <= 7'd0;
      reg_q      <= 8'd0;
      wdata_q    <= 8'd0;
      tx_data_q  <= 8'd0;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      rnw_q      <= rnw_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef I2C_SEQ_WDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              tmo_q;
  logic              in_wait;

  assign in_wait = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO) ||
                   (state_q == S_RD_REQ)  || (state_q == S_RD_WAIT_HI);

  // Counter is 0 in the first cycle of a wait state, so expiry after
  // WDOG_CYC cycles there is detected when it holds WDOG_CYC-1.
  assign wdog_hit = in_wait && (wdog_q == WDOG_W'(WDOG_CYC - 1));

  always_comb begin
    wdog_d = '0;
    if (in_wait && (state_d == state_q)) wdog_d = wdog_q + WDOG_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tmo_q  <= tmo_set;
    end
  end

  // tmo_q is only ever high in the FINISH cycle that follows an expiry.
  assign ERR_TIMEOUT = tmo_q;
`else
  logic unused_wdog;
  assign wdog_hit    = 1'b0;
  assign unused_wdog = ^{WDOG_W'(WDOG_CYC), tmo_set};
  assign ERR_TIMEOUT = 1'b0;
`endif

  // Strobes decode straight from state so each lasts exactly one state visit;
  // RX_REQ falls the cycle after RX_WE_N is seen low, well before it rises.
  assign CMD_READY = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);
  assign TX_WE     = (state_q == S_SEND);
  assign RX_REQ    = (state_q == S_RD_REQ);
  assign DONE      = (state_q == S_FINISH);
  assign TX_DATA   = tx_data_q;
  assign RD_DATA   = rd_data_q;
  assign RD_VALID  = rd_valid_q;

endmodule
